// File: rtl/score_display_mux.sv
// rtl/score_display_mux.sv - four-digit multiplexed seven-segment score display
module score_display_mux #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] units_place,
    input  logic [3:0] tens_place,
    input  logic [3:0] hundreds_place,
    input  logic [3:0] thousands_place,
    input  logic       blink,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int             CW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]  REFRESH_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [7:0]     FRAME_LAST   = 8'(BLINK_FRAMES - 1);

    logic [CW-1:0] refresh_cnt;
    logic [1:0]    slot;
    logic [7:0]    frame_cnt;
    logic          blink_phase;
    logic [3:0]    sh_units, sh_tens, sh_hundreds, sh_thousands;

    logic          slot_tick;
    logic          frame_start;
    logic [3:0]    digit;
    logic          blanked;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;

    // Segment patterns are g..a, active low; anything outside BCD shows a dash.
    function automatic logic [6:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    encode = 7'b1000000;
            4'd1:    encode = 7'b1111001;
            4'd2:    encode = 7'b0100100;
            4'd3:    encode = 7'b0110000;
            4'd4:    encode = 7'b0011001;
            4'd5:    encode = 7'b0010010;
            4'd6:    encode = 7'b0000010;
            4'd7:    encode = 7'b1111000;
            4'd8:    encode = 7'b0000000;
            4'd9:    encode = 7'b0010000;
            default: encode = 7'b0111111;
        endcase
    endfunction

    assign slot_tick   = (refresh_cnt == REFRESH_LAST);
    assign frame_start = slot_tick && (slot == 2'd3);
    assign dp          = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt  <= '0;
            slot         <= 2'd0;
            frame_cnt    <= 8'd0;
            blink_phase  <= 1'b0;
            sh_units     <= 4'd0;
            sh_tens      <= 4'd0;
            sh_hundreds  <= 4'd0;
            sh_thousands <= 4'd0;
        end else begin
            refresh_cnt <= slot_tick ? '0 : refresh_cnt + 1'b1;
            if (slot_tick) begin
                slot <= slot + 2'd1;
            end
            // Digits are latched only at frame boundaries so a frame never mixes two scores.
            if (frame_start) begin
                sh_units     <= units_place;
                sh_tens      <= tens_place;
                sh_hundreds  <= hundreds_place;
                sh_thousands <= thousands_place;
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt   <= 8'd0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

    always_comb begin
        digit   = sh_units;
        blanked = 1'b0;
        case (slot)
            2'd0: begin
                digit   = sh_units;
                blanked = 1'b0;
            end
            2'd1: begin
                digit   = sh_tens;
                blanked = (sh_thousands == 4'd0) && (sh_hundreds == 4'd0) && (sh_tens == 4'd0);
            end
            2'd2: begin
                digit   = sh_hundreds;
                blanked = (sh_thousands == 4'd0) && (sh_hundreds == 4'd0);
            end
            default: begin
                digit   = sh_thousands;
                blanked = (sh_thousands == 4'd0);
            end
        endcase
    end

    always_comb begin
        an_d  = 4'b1111;
        seg_d = 7'h7F;
        if (!blanked && !(blink && blink_phase)) begin
            an_d  = ~(4'b0001 << slot);
            seg_d = encode(digit);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
        end else begin
            an  <= an_d;
            seg <= seg_d;
        end
    end

endmodule

// File: tb/tb_score_display_mux.sv
// tb/tb_score_display_mux.sv - randomized self-checking bench for score_display_mux
module tb_score_display_mux;

    localparam int DIV    = 4;
    localparam int FRAMES = 2;
    localparam int FRAME_CYC = 4 * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] units_place = 4'd0;
    logic [3:0] tens_place = 4'd0;
    logic [3:0] hundreds_place = 4'd0;
    logic [3:0] thousands_place = 4'd0;
    logic       blink = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;

    // Reference model state: clocks since reset release and the digits latched at the last frame start.
    int         k = 0;
    logic [3:0] sh [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    logic [6:0] seg_table [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                   7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    score_display_mux #(.REFRESH_DIV(DIV), .BLINK_FRAMES(FRAMES)) dut (
        .clk(clk),
        .reset(reset),
        .units_place(units_place),
        .tens_place(tens_place),
        .hundreds_place(hundreds_place),
        .thousands_place(thousands_place),
        .blink(blink),
        .an(an),
        .seg(seg),
        .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t k=%0d: got %h expected %h", tag, $time, k, got, exp);
        end
    endtask

    task automatic step();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        int         n, slot, frame;
        logic       phase, dark;
        @(posedge clk);
        e_an  = 4'b1111;
        e_seg = 7'h7F;
        if (reset) begin
            k  = 0;
            sh = '{4'd0, 4'd0, 4'd0, 4'd0};
        end else begin
            k++;
            n     = k - 1;
            slot  = (n / DIV) % 4;
            frame = n / FRAME_CYC;
            phase = ((frame / FRAMES) % 2) == 1;
            // A slot is dark if every digit at or above it is zero (units always lit).
            dark = (slot != 0);
            for (int j = slot; j < 4; j++) begin
                if (sh[j] != 4'd0) dark = 1'b0;
            end
            if (blink && phase) dark = 1'b1;
            if (!dark) begin
                e_an  = 4'b1111;
                e_an[slot] = 1'b0;
                e_seg = (sh[slot] < 4'd10) ? seg_table[sh[slot]] : 7'b0111111;
            end
            if (k % FRAME_CYC == 0) begin
                sh[0] = units_place;
                sh[1] = tens_place;
                sh[2] = hundreds_place;
                sh[3] = thousands_place;
            end
        end
        #1;
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'd1);
    endtask

    task automatic cyc(input logic r, input logic b, input logic [15:0] digits);
        @(negedge clk);
        reset           = r;
        blink           = b;
        thousands_place = digits[15:12];
        hundreds_place  = digits[11:8];
        tens_place      = digits[7:4];
        units_place     = digits[3:0];
        step();
    endtask

    logic [15:0] scen [5] = '{16'h1234, 16'h0007, 16'h0500, 16'h000C, 16'h0003};
    logic [15:0] cur;
    logic        cur_blink;
    int          rst_left;

    initial begin
        repeat (3) cyc(1'b1, 1'b0, 16'h0000);

        // Directed digit patterns, each held for three frames.
        foreach (scen[i]) begin
            for (int c = 0; c < 3 * FRAME_CYC; c++) cyc(1'b0, 1'b0, scen[i]);
        end

        // Units changes mid-frame (during slot 2) from 3 to 8.
        cyc(1'b1, 1'b0, 16'h0003);
        for (int c = 0; c < 2 * FRAME_CYC + 2 * DIV; c++) cyc(1'b0, 1'b0, 16'h0003);
        for (int c = 0; c < 2 * FRAME_CYC; c++) cyc(1'b0, 1'b0, 16'h0008);

        // Blink held for eight frames with a reset pulse in the middle.
        cyc(1'b1, 1'b0, 16'h1234);
        for (int c = 0; c < 8 * FRAME_CYC; c++) begin
            cyc((c == 70 || c == 71) ? 1'b1 : 1'b0, 1'b1, 16'h1234);
        end

        // Randomized digits, blink and occasional reset pulses.
        cur       = 16'h0000;
        cur_blink = 1'b0;
        rst_left  = 0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(3))
                    0: cur = 16'($urandom);
                    1: cur = {12'h000, 4'($urandom_range(15))};
                    2: cur = {8'h00, 4'($urandom_range(9)), 4'($urandom_range(9))};
                    default: cur = {4'h0, 4'($urandom_range(9)), 8'h00};
                endcase
            end
            if ($urandom_range(63) == 0) cur_blink = ~cur_blink;
            if (rst_left == 0 && $urandom_range(299) == 0) rst_left = $urandom_range(1, 3);
            cyc(rst_left != 0, cur_blink, cur);
            if (rst_left != 0) rst_left--;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_display_mux.md
SCORE_DISPLAY_MUX -- requirements
Module: score_display_mux

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clock cycles per digit slot; legal range 2..2^20.
REQ-002 Parameter BLINK_FRAMES, default 64, scan frames per blink half-period; legal range 1..255.
REQ-003 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port units_place  input  4  BCD units digit from the score converter.
REQ-006 Port tens_place  input  4  BCD tens digit.
REQ-007 Port hundreds_place  input  4  BCD hundreds digit.
REQ-008 Port thousands_place  input  4  BCD thousands digit.
REQ-009 Port blink  input  1  high = flash whole display (game-over indication).
REQ-010 Port an  output  4  active-low digit enables; an[0] = units, an[3] = thousands.
REQ-011 Port seg  output  7  active-low segments; seg[0] = a … seg[6] = g.
REQ-012 Port dp  output  1  active-low decimal point; constant 1 (off) in this block.

Function
REQ-013 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; the wrap cycle is the slot tick.
REQ-014 The 2-bit slot index SHALL advance 0→1→2→3→0 on each slot tick and hold otherwise.
REQ-015 A frame start is the slot tick that moves the index from 3 to 0.
REQ-016 At each frame start, the block SHALL copy all four digit inputs into shadow registers; the display SHALL use only the shadow values (no tearing within a frame).
REQ-017 Digit inputs changing mid-frame SHALL have no visible effect until the next frame start.
REQ-018 Leading-zero blanking SHALL use the shadow values: thousands blanked if 0; hundreds blanked if thousands and hundreds are both 0; tens blanked if thousands, hundreds and tens are all 0; units never blanked.
REQ-019 A blanked slot SHALL drive its an bit 1 and seg = 7'h7F.
REQ-020 Segment codes (g..a) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-021 A shadow digit value 10..15 SHALL display a dash (seg = 0111111) and SHALL count as non-zero for blanking.
REQ-022 The frame counter SHALL increment at each frame start and wrap at BLINK_FRAMES-1; at each wrap, blink_phase SHALL toggle.
REQ-023 When blink = 1 and blink_phase = 1, the block SHALL drive an = 4'b1111 and seg = 7'h7F.
REQ-024 When blink = 0, blink_phase SHALL continue toggling but SHALL have no visible effect.
REQ-025 an and seg SHALL be registered and SHALL reflect the new slot index one clock after the slot tick.
REQ-026 Exactly one an bit SHALL be 0 in any cycle, except in blanked or blink-off cycles, where all an bits SHALL be 1.

Reset
REQ-027 While reset = 1, the refresh counter, slot index, frame counter, blink_phase and all shadow registers SHALL clear to 0.
REQ-028 While reset = 1, outputs SHALL be an = 4'b1111, seg = 7'h7F and dp = 1.
REQ-029 On the first clock after reset deasserts, outputs SHALL show slot 0 (an = 4'b1110, seg = 1000000); the inputs SHALL first be sampled at the first frame start, 4*REFRESH_DIV cycles after reset deasserts.
REQ-030 Reset asserted mid-frame SHALL take effect on the next clock edge, discarding any partially displayed frame.

Verification (REFRESH_DIV = 4, BLINK_FRAMES = 2)
REQ-031 Digits 1,2,3,4 (thousands..units), after the first frame start -> the an sequence 1110, 1101, 1011, 0111, each held 4 cycles, with seg 0011001, 0110000, 0100100, 1111001.
REQ-032 Digits 0,0,0,7 -> only the units slot lit (seg = 1111000); an = 1111 during the tens, hundreds and thousands slots.
REQ-033 Digits 0,5,0,0 -> thousands blanked; hundreds shows 5 (0010010); tens and units each show 0.
REQ-034 Units input changed from 3 to 8 during slot 2 -> units slot keeps showing 3 for the rest of the frame; 8 appears from the next frame.
REQ-035 blink = 1 held for 8 frames -> display alternates 2 frames dark (an = 1111) and 2 frames lit; reset pulsed mid-sequence -> an = 1111 during reset, then an = 1110 the next clock.
REQ-036 Units input = 4'hC -> units slot shows a dash (0111111); with all other digits 0, tens, hundreds and thousands stay blanked.
